// File: rtl/ll_page_walker_pkg.sv
// Shared types and width helpers for the link-list page walker slice.
package ll_page_walker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RDREQ,
        RDRSP,
        RETWAIT,
        FIN
    } walk_state_e;

    // Link data is one bit wider than a page number; the extra msb flags the stop page.
    function automatic int unsigned stop_bit(input int unsigned lpsz);
        return lpsz;
    endfunction

    function automatic int unsigned port_w(input int unsigned ports);
        return (ports < 2) ? 1 : $clog2(ports);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned maxpg);
        return $clog2(maxpg + 1);
    endfunction

endpackage

// File: rtl/ll_page_walker_if.sv
// Handshake bundle between the page walker and its queues, link RAM, free list and completion sink.
interface ll_page_walker_if
    import ll_page_walker_pkg::*;
#(
    parameter int unsigned lpsz  = 8,
    parameter int unsigned ports = 4,
    parameter int unsigned maxpg = 64
);
    localparam int unsigned lpdsz = lpsz + 1;
    localparam int unsigned pw    = port_w(ports);
    localparam int unsigned cw    = cnt_w(maxpg);

    logic [ports-1:0]      op_srdy;
    logic [ports-1:0]      op_drdy;
    logic [ports*lpsz-1:0] op_page;
    logic                  rlp_srdy;
    logic                  rlp_drdy;
    logic [lpsz-1:0]       rlp_rd_page;
    logic                  rlpr_srdy;
    logic                  rlpr_drdy;
    logic [lpdsz-1:0]      rlpr_data;
    logic                  lprt_srdy;
    logic                  lprt_drdy;
    logic [lpsz-1:0]       lprt_page_list;
    logic                  done_srdy;
    logic                  done_drdy;
    logic [pw-1:0]         done_port;
    logic [cw-1:0]         done_pgcount;
    logic                  done_err;

    modport master (
        input  op_srdy, op_page, rlp_drdy, rlpr_srdy, rlpr_data, lprt_drdy, done_drdy,
        output op_drdy, rlp_srdy, rlp_rd_page, rlpr_drdy, lprt_srdy, lprt_page_list,
               done_srdy, done_port, done_pgcount, done_err
    );

    modport slave (
        output op_srdy, op_page, rlp_drdy, rlpr_srdy, rlpr_data, lprt_drdy, done_drdy,
        input  op_drdy, rlp_srdy, rlp_rd_page, rlpr_drdy, lprt_srdy, lprt_page_list,
               done_srdy, done_port, done_pgcount, done_err
    );

endinterface

// File: rtl/ll_rr_arb.sv
// Round-robin arbiter; search starts at the pointer, which moves past each winner.
module ll_rr_arb
    import ll_page_walker_pkg::*;
#(
    parameter  int unsigned ports = 4,
    localparam int unsigned pw    = port_w(ports)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [ports-1:0] req_i,
    output logic             gnt_v_o,
    output logic [pw-1:0]    gnt_idx_o
);

    logic [pw-1:0] ptr_q;
    logic [pw-1:0] idx;

    always_comb begin
        gnt_v_o   = 1'b0;
        gnt_idx_o = '0;
        idx       = '0;
        if (en_i) begin
            for (int unsigned off = 0; off < ports; off++) begin
                idx = pw'((32'(ptr_q) + off) % ports);
                if (!gnt_v_o && req_i[idx]) begin
                    gnt_v_o   = 1'b1;
                    gnt_idx_o = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (gnt_v_o) begin
            ptr_q <= (gnt_idx_o == pw'(ports - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/ll_page_walker.sv
// Walks one packet's page chain at a time, returning each page and posting a completion record.
module ll_page_walker
    import ll_page_walker_pkg::*;
#(
    parameter int unsigned lpsz  = 8,
    parameter int unsigned ports = 4,
    parameter int unsigned maxpg = 64
) (
    input logic             clk,
    input logic             reset,
    ll_page_walker_if.master bus
);

    localparam int unsigned pw = port_w(ports);
    localparam int unsigned cw = cnt_w(maxpg);
    localparam int unsigned sb = stop_bit(lpsz);

    walk_state_e       state_q, state_d;
    logic [ports-1:0]  hold_v_q, hold_v_d;
    logic [lpsz-1:0]   hold_pg_q [ports];
    logic [lpsz-1:0]   cur_q, cur_d;
    logic [lpsz:0]     nxt_q, nxt_d;
    logic [cw-1:0]     cnt_q, cnt_d;
    logic [pw-1:0]     port_q, port_d;
    logic              err_q, err_d;
    logic              rb_v_q, rb_v_d;
    logic [lpsz-1:0]   rb_pg_q;
    logic              gnt_v;
    logic [pw-1:0]     gnt_idx;
    logic              rb_free, push, adv, stop, abort;
    logic [lpsz:0]     link;
    logic [cw-1:0]     link_cnt;

    ll_rr_arb #(.ports(ports)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (state_q == IDLE),
        .req_i     (hold_v_q),
        .gnt_v_o   (gnt_v),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        hold_v_d = hold_v_q | (bus.op_srdy & ~hold_v_q);
        if (gnt_v) hold_v_d[gnt_idx] = 1'b0;
    end

    // A response that meets a full, non-draining buffer is parked in nxt_q/cnt_q and
    // replayed from RETWAIT, so both states share the advance decision below.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        cnt_d    = cnt_q;
        port_d   = port_q;
        err_d    = err_q;
        push     = 1'b0;
        adv      = 1'b0;
        rb_free  = !rb_v_q || bus.lprt_drdy;
        link     = (state_q == RDRSP) ? bus.rlpr_data : nxt_q;
        link_cnt = (state_q == RDRSP) ? cnt_q + 1'b1 : cnt_q;
        stop     = link[sb];
        abort    = !stop && (link_cnt == cw'(maxpg));
        unique case (state_q)
            IDLE: if (gnt_v) begin
                state_d = RDREQ;
                cur_d   = hold_pg_q[gnt_idx];
                port_d  = gnt_idx;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            RDREQ: if (bus.rlp_drdy) state_d = RDRSP;
            RDRSP: if (bus.rlpr_srdy) begin
                nxt_d = link;
                cnt_d = link_cnt;
                if (rb_free) adv = 1'b1;
                else         state_d = RETWAIT;
            end
            RETWAIT: if (rb_free) adv = 1'b1;
            FIN: if (!rb_v_q && bus.done_drdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            push = 1'b1;
            if (stop || abort) begin
                state_d = FIN;
                err_d   = abort;
            end else begin
                state_d = RDREQ;
                cur_d   = link[lpsz-1:0];
            end
        end
        rb_v_d = (rb_v_q && !bus.lprt_drdy) || push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            hold_v_q <= '0;
            for (int unsigned i = 0; i < ports; i++) hold_pg_q[i] <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            cnt_q    <= '0;
            port_q   <= '0;
            err_q    <= 1'b0;
            rb_v_q   <= 1'b0;
            rb_pg_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_v_q <= hold_v_d;
            for (int unsigned i = 0; i < ports; i++) begin
                if (bus.op_srdy[i] && !hold_v_q[i]) hold_pg_q[i] <= bus.op_page[i*lpsz +: lpsz];
            end
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            err_q    <= err_d;
            rb_v_q   <= rb_v_d;
            if (push) rb_pg_q <= cur_q;
        end
    end

    assign bus.op_drdy        = ~hold_v_q;
    assign bus.rlp_srdy       = (state_q == RDREQ);
    assign bus.rlp_rd_page    = cur_q;
    assign bus.rlpr_drdy      = (state_q == RDRSP);
    assign bus.lprt_srdy      = rb_v_q;
    assign bus.lprt_page_list = rb_pg_q;
    assign bus.done_srdy      = (state_q == FIN) && !rb_v_q;
    assign bus.done_port      = port_q;
    assign bus.done_pgcount   = cnt_q;
    assign bus.done_err       = err_q;

endmodule

// File: doc/ll_page_walker.md
Name: ll_page_walker

Overview:
- Synthesizable multi-port link-list page walker for the link list manager.
- Accepts packet head pages from `ports` output-port queues and selects among them round-robin.
- For each packet: walks the page chain through the read-link-page interface and returns every page on the reclaim interface, then posts one completion record per packet.
- Adds concurrent page return, a runaway-chain limit and completion reporting.

Parameters:
- lpsz, 8, page number width.
- ports, 4, number of output-port head queues (>=2).
- maxpg, 64, maximum pages walked per packet before abort (1..2^cw-1).
- Derived localparams: lpdsz=lpsz+1 (link data width, msb = stop flag); pw=clog2(ports); cw=clog2(maxpg+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- op_srdy  in  ports  head page valid, per port.
- op_drdy  out  ports  head page accepted, per port.
- op_page  in  ports*lpsz  head pages; port i at [i*lpsz +: lpsz].
- rlp_srdy  out  1  link read request valid.
- rlp_drdy  in  1  link read request accepted.
- rlp_rd_page  out  lpsz  page whose link is read.
- rlpr_srdy  in  1  link read response valid.
- rlpr_drdy  out  1  response accepted.
- rlpr_data  in  lpdsz  next page; msb=1 means stop page.
- lprt_srdy  out  1  page return valid.
- lprt_drdy  in  1  page return accepted.
- lprt_page_list  out  lpsz  returned page.
- done_srdy  out  1  completion valid.
- done_drdy  in  1  completion accepted.
- done_port  out  pw  port of completed packet.
- done_pgcount  out  cw  pages returned for the packet.
- done_err  out  1  chain aborted at maxpg.

Behaviour:
- Reset (async assert, sync release): all srdy/drdy outputs 0 except op_drdy = all-ones; data outputs 0; FSM in IDLE; RR pointer 0; holding regs and return buffer empty.
- Head capture: per port one holding reg; op_drdy[i] = !hold_v[i]. Page captured on op_srdy&op_drdy. Visible to the arbiter next cycle.
- Arbiter (IDLE only): round-robin starting at ptr; grant clears hold_v[g]; ptr <= g+1 (mod ports, wraps). No grant when all empty.
- FSM states:
  - IDLE -> RDREQ on grant; cur=page, cnt=0.
  - RDREQ: rlp_srdy=1, rlp_rd_page=cur (registered). On rlp_drdy -> RDRSP.
  - RDRSP: rlpr_drdy=1. On rlpr_srdy: nxt=rlpr_data, cnt=cnt+1.
    - If return buffer is empty or draining this cycle: cur is pushed; go RDREQ (cur=nxt[lpsz-1:0]) or FIN.
    - Otherwise hold nxt -> RETWAIT.
  - RETWAIT: push cur when the buffer frees, then as above.
  - Stop case: nxt msb=1 -> FIN. Abort case: cnt reaches maxpg with msb=0 -> FIN with err=1; remainder of the chain is not walked.
  - FIN: done_srdy asserted only once the return buffer is empty, i.e. all pages of the packet accepted. Outputs are port, cnt, err. On done_drdy -> IDLE.
- Return buffer: 1 entry. lprt_srdy=valid; cleared on lprt_drdy. Push and pop in the same cycle is allowed. A page return overlaps the next link read.
- Ordering: pages are returned in chain order. Completions are issued in walk order; one packet is in flight at a time.
- rlpr_srdy outside RDRSP/RETWAIT is ignored (rlpr_drdy=0).
- All srdy outputs are held stable with their data until the matching drdy.
- Reset mid-walk: abandons the walk, its pages and the completion; outstanding responses are not tracked.

Decomposition:
- Shared package: stop flag bit index (lpdsz-1); FSM state encoding (IDLE, RDREQ, RDRSP, RETWAIT, FIN); widths pw and cw as functions.
- Sub-module: ll_rr_arb (ports-wide round-robin arbiter with pointer update on grant).
- Holding regs, FSM and return buffer live in the top module.

Test Plan:
- Single packet, port 0: head 3, links 3->5, 5->9, 9->stop (9'h100). Required: reads 3,5,9; returns 3,5,9 in order; then done port=0, pgcount=3, err=0.
- Heads on all 4 ports in the same cycle, one page each. Required: walk order 0,1,2,3; next round after ptr wrap starts at port 0.
- lprt_drdy held low for 20 cycles during a 4-page packet. Required: FSM parks in RETWAIT after the second response; no page lost or duplicated; done only after the 4th return.
- maxpg=4, circular chain 1->2->1->... Required: exactly 4 pages returned (1,2,1,2); done pgcount=4, err=1; FSM back in IDLE.
- done_drdy low for 10 cycles while port 2 has a new head. Required: op_drdy[2]=0 after capture; next walk starts only after the done handshake.
- reset pulsed low during RDRSP. Required: all srdy outputs 0 asynchronously, op_drdy=4'hF; after release, a new packet walks correctly.
